svf_ctrl: RTL and testbench
===========================

Name: svf_ctrl

Overview:
- Digital control front-end that drives the switched-capacitor SVF macro's control pins: sc_clk, the q0..q3 C_Q switches and sel0/sel1.
- Holds a configuration (divider, Q code, mode) loaded through a valid/ready handshake.
- Generates sc_clk with a programmable divider and applies new settings only at a safe sc_clk phase boundary.
- Emits a sample strobe to the ADC once per filter iteration.

Parameters:
- DIV_W, 11, width of the half-period divider value (cfg_fc).
- MIN_DIV, 2, minimum effective nonzero half-period in clk cycles; smaller nonzero values are clamped up to it.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  controller can accept a configuration.
- cfg_fc  in  DIV_W  sc_clk half-period in clk cycles; 0 = stop sc_clk.
- cfg_res  in  4  target Q code {q3,q2,q1,q0}.
- cfg_mode  in  2  {sel1,sel0}: 00 LP, 01 BP, 10 HP, 11 bypass.
- sc_clk  out  1  SC switching clock to the macro.
- q0, q1, q2, q3  out  1 each  C_Q array switch controls.
- sel0, sel1  out  1 each  output select.
- sample_stb  out  1  one-cycle ADC sample pulse.
- busy  out  1  a configuration is accepted but not yet applied.

Behaviour:
- Reset (asynchronous, on rst_n low):
  - sc_clk=0; q0..q3=0; sel=11 (bypass).
  - Active divider = 0 (stopped); cnt=0; state=STOP.
  - cfg_ready=1; busy=0; sample_stb=0.
- Divider:
  - Effective N = 0 if cfg_fc==0, else max(cfg_fc, MIN_DIV).
  - Down-counter cnt is loaded with N-1 on each toggle. When cnt==0, sc_clk toggles and cnt reloads.
  - sc_clk period = 2N clk cycles at 50% duty. All outputs are registered.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready. The values are captured into a pending register.
  - Next cycle: cfg_ready=0, busy=1.
  - cfg_ready returns to 1 on the cycle after the pending configuration is applied. Only one configuration can be outstanding.
- States:
  - STOP: sc_clk held 0, outputs static. A transfer is applied on the next cycle. Go to RUN if N!=0, with cnt=N-1 and sc_clk low; otherwise remain in STOP.
  - RUN: free-running. A transfer moves to PEND.
  - PEND: still running. On the cycle where cnt==0 and sc_clk==1 (the falling toggle):
    - sc_clk goes to 0.
    - The new N, q, sel (or the soft-Q target) and cnt=N-1 are loaded together.
    - Next state is RUN, or STOP if N==0.
- Changes are never applied mid-high phase. sc_clk never produces a high pulse shorter than the old N.
- sample_stb: one-cycle pulse, registered, asserted in the same cycle sc_clk falls, in RUN or PEND. The macro updates on posedge, so its output has had N cycles to settle. No pulse is produced in STOP.
- A cfg_fc write that only changes sel or q, with equal N, still waits for the falling edge.
- When rst_n is asserted mid-PEND, the pending configuration is discarded.

Optional Feature:
- SVF_CTRL_SOFT_Q_EN defined:
  - The applied Q code does not jump to the target. On every sample_stb, the q code steps by one LSB toward the target until it is equal.
  - busy stays 1 until q equals the target. cfg_ready also stays 0 until then.
  - In STOP, the code jumps directly to the target.
- SVF_CTRL_SOFT_Q_EN undefined:
  - q is loaded directly with the target at the apply point.
  - The step logic is absent.

Decomposition:
- Package svf_ctrl_pkg holds:
  - mode encodings SVF_LP=2'b00, SVF_BP=2'b01, SVF_HP=2'b10, SVF_BYP=2'b11;
  - the state enum {STOP, RUN, PEND};
  - the default divider width.
- One natural sub-module, svf_clkdiv: the counter, toggle and fall-edge indication. It takes the load value and a load strobe.

Test Plan:
- After reset, write fc=4, res=5, mode=00 → outputs apply 1 cycle later:
  - sc_clk toggles every 4 clk (period 8);
  - {q3..q0}=0101, sel=00;
  - sample_stb pulses once per 8 cycles, on falls.
- While running at fc=4, write fc=10, res=2, mode=10 → cfg_ready=0 and busy=1 until the next falling edge; then period becomes 20. The last high phase is exactly 4 cycles.
- Write fc=1 → clamped. The period measures 4 (MIN_DIV=2).
- Write fc=0 while running → sc_clk goes low at the next fall and stays low. No further sample_stb.
- Hold cfg_valid through PEND with different data → a second transfer occurs only after apply; the first configuration is not corrupted.
- Assert rst_n low mid-PEND → all outputs return to reset values immediately. A SOFT_Q_EN build stepping from 0 to 15 at fc=4 reaches 15 after 15 strobes, then busy drops.

Source files
------------

// File: rtl/svf_ctrl_pkg.sv
// Shared definitions for the SVF control front-end: mode encodings, FSM states
// and the default divider width.
package svf_ctrl_pkg;

    localparam int SVF_DIV_W = 11;

    localparam logic [1:0] SVF_LP  = 2'b00;
    localparam logic [1:0] SVF_BP  = 2'b01;
    localparam logic [1:0] SVF_HP  = 2'b10;
    localparam logic [1:0] SVF_BYP = 2'b11;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } svf_state_e;

endpackage

// File: rtl/svf_clkdiv.sv
// sc_clk generator: half-period down-counter with toggle and a falling-toggle
// indication; a load forces sc_clk low and restarts the count.
module svf_clkdiv #(
    parameter int DIV_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic [DIV_W-1:0] reload_val_i,
    output logic             sc_clk_o,
    output logic             fall_o
);

    logic [DIV_W-1:0] cnt_q;
    logic             sc_clk_q;

    // High with the counter expired means the next edge is the falling toggle.
    assign fall_o   = run_i && (cnt_q == '0) && sc_clk_q;
    assign sc_clk_o = sc_clk_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sc_clk_q <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= load_val_i;
            sc_clk_q <= 1'b0;
        end else if (run_i) begin
            if (cnt_q == '0) begin
                sc_clk_q <= ~sc_clk_q;
                cnt_q    <= reload_val_i;
            end else begin
                cnt_q <= cnt_q - DIV_W'(1);
            end
        end else begin
            sc_clk_q <= 1'b0;
        end
    end

endmodule

// File: rtl/svf_ctrl.sv
// SVF macro control front-end: config handshake, safe-phase apply, sc_clk and
// ADC strobe. Optional gradual Q stepping when SVF_CTRL_SOFT_Q_EN is defined.
module svf_ctrl
    import svf_ctrl_pkg::*;
#(
    parameter int DIV_W   = SVF_DIV_W,
    parameter int MIN_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_fc,
    input  logic [3:0]       cfg_res,
    input  logic [1:0]       cfg_mode,
    output logic             sc_clk,
    output logic             q0,
    output logic             q1,
    output logic             q2,
    output logic             q3,
    output logic             sel0,
    output logic             sel1,
    output logic             sample_stb,
    output logic             busy
);

    svf_state_e       state_q;
    logic [DIV_W-1:0] div_q;
    logic             pend_q;
    logic [DIV_W-1:0] pend_n_q;
    logic [3:0]       pend_res_q;
    logic [1:0]       pend_mode_q;
    logic [3:0]       q_q;
    logic [1:0]       sel_q;
    logic             ready_q;
    logic             busy_q;
    logic             stb_q;

    logic [DIV_W-1:0] cfg_n_d;
    logic [DIV_W-1:0] load_val_d;
    logic             xfer;
    logic             fall;
    logic             apply_now;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cfg_n_d = cfg_fc;
        if (cfg_fc != '0 && cfg_fc < DIV_W'(MIN_DIV))
            cfg_n_d = DIV_W'(MIN_DIV);
    end

    assign xfer       = cfg_valid && ready_q;
    assign apply_now  = ((state_q == STOP) && pend_q) || ((state_q == PEND) && fall);
    assign load_val_d = (pend_n_q == '0) ? '0 : pend_n_q - DIV_W'(1);

    svf_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (state_q != STOP),
        .load_i       (apply_now),
        .load_val_i   (load_val_d),
        .reload_val_i (div_q - DIV_W'(1)),
        .sc_clk_o     (sc_clk),
        .fall_o       (fall)
    );

`ifdef SVF_CTRL_SOFT_Q_EN
    logic [3:0] target_q;
    logic [3:0] q_step_d;

    always_comb begin
        q_step_d = q_q;
        if (q_q < target_q)
            q_step_d = q_q + 4'd1;
        else if (q_q > target_q)
            q_step_d = q_q - 4'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STOP;
            div_q       <= '0;
            pend_q      <= 1'b0;
            pend_n_q    <= '0;
            pend_res_q  <= '0;
            pend_mode_q <= SVF_BYP;
            q_q         <= '0;
            sel_q       <= SVF_BYP;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            stb_q       <= 1'b0;
`ifdef SVF_CTRL_SOFT_Q_EN
            target_q    <= '0;
`endif
        end else begin
            stb_q <= fall;

            if (xfer) begin
                pend_q      <= 1'b1;
                pend_n_q    <= cfg_n_d;
                pend_res_q  <= cfg_res;
                pend_mode_q <= cfg_mode;
                ready_q     <= 1'b0;
                busy_q      <= 1'b1;
            end

            case (state_q)
                STOP:    if (pend_q) state_q <= (pend_n_q != '0) ? RUN : STOP;
                RUN:     if (xfer)   state_q <= PEND;
                PEND:    if (fall)   state_q <= (pend_n_q != '0) ? RUN : STOP;
                default: state_q <= STOP;
            endcase

            // Divider, mode and Q change together, only with sc_clk low.
            if (apply_now) begin
                pend_q <= 1'b0;
                div_q  <= pend_n_q;
                sel_q  <= pend_mode_q;
`ifdef SVF_CTRL_SOFT_Q_EN
                target_q <= pend_res_q;
                if (state_q == STOP || q_q == pend_res_q) begin
                    q_q     <= pend_res_q;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
`else
                q_q     <= pend_res_q;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
`endif
            end

`ifdef SVF_CTRL_SOFT_Q_EN
            if (state_q == RUN && fall && q_q != target_q) begin
                q_q <= q_step_d;
                if (q_step_d == target_q) begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            end
`endif
        end
    end

    assign cfg_ready  = ready_q;
    assign busy       = busy_q;
    assign sample_stb = stb_q;
    assign q0         = q_q[0];
    assign q1         = q_q[1];
    assign q2         = q_q[2];
    assign q3         = q_q[3];
    assign sel0       = sel_q[0];
    assign sel1       = sel_q[1];

endmodule

// File: tb/tb_svf_ctrl.sv
// Directed bench for svf_ctrl; the soft-Q scenario runs when SVF_CTRL_SOFT_Q_EN is defined.
module tb_svf_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [10:0] cfg_fc = '0;
    logic [3:0]  cfg_res = '0;
    logic [1:0]  cfg_mode = '0;
    logic        sc_clk, q0, q1, q2, q3, sel0, sel1, sample_stb, busy;
    logic [3:0]  q_obs;
    logic [1:0]  sel_obs;

    int n_checks = 0;
    int n_fail   = 0;

    assign q_obs   = {q3, q2, q1, q0};
    assign sel_obs = {sel1, sel0};

    always #5 clk = ~clk;

    svf_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_fc     (cfg_fc),
        .cfg_res    (cfg_res),
        .cfg_mode   (cfg_mode),
        .sc_clk     (sc_clk),
        .q0         (q0),
        .q1         (q1),
        .q2         (q2),
        .q3         (q3),
        .sel0       (sel0),
        .sel1       (sel1),
        .sample_stb (sample_stb),
        .busy       (busy)
    );

    // Compares the full output vector against the reset values.
    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({sc_clk, q_obs, sel_obs, cfg_ready, busy, sample_stb} !== 10'b0_0000_11_1_0_0) begin
            n_fail++;
            $display("FAIL %s: got sc=%b q=%b sel=%b rdy=%b busy=%b stb=%b want sc=0 q=0000 sel=11 rdy=1 busy=0 stb=0",
                     tag, sc_clk, q_obs, sel_obs, cfg_ready, busy, sample_stb);
        end
    endtask

    task automatic send(input logic [10:0] fc, input logic [3:0] res, input logic [1:0] mode,
                        input string tag);
        int n = 0;
        cfg_fc = fc; cfg_res = res; cfg_mode = mode; cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_timeout: cfg_ready=%b want 1", tag, cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_fall(input string tag);
        int n = 0;
        @(negedge clk);
        while (sample_stb !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (sample_stb !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_wait_fall: sample_stb=%b want 1 within 200 cycles", tag, sample_stb);
        end
    endtask

    // Waits for a rising sc_clk, then counts one high and one low phase.
    task automatic measure(input string tag, output int hi, output int lo,
                           output int stb, output logic stb_first);
        int n = 0;
        hi = 0; lo = 0; stb = 0; stb_first = 1'b0;
        while (sc_clk !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        while (sc_clk !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        while (sc_clk === 1'b1 && n < 400) begin
            hi++; stb += int'(sample_stb); @(negedge clk); n++;
        end
        stb_first = sample_stb;
        while (sc_clk === 1'b0 && n < 400) begin
            lo++; stb += int'(sample_stb); @(negedge clk); n++;
        end
        n_checks++;
        if (n >= 400) begin
            n_fail++;
            $display("FAIL %s_measure_timeout: ran %0d cycles want < 400", tag, n);
        end
    endtask

    task automatic check_period(input string tag, input int exp_half);
        int hi, lo, stb;
        logic stb_first;
        measure(tag, hi, lo, stb, stb_first);
        n_checks++;
        if (hi != exp_half || lo != exp_half) begin
            n_fail++;
            $display("FAIL %s_period: got hi=%0d lo=%0d want %0d/%0d", tag, hi, lo, exp_half, exp_half);
        end
        n_checks++;
        if (stb != 1 || stb_first !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_strobe: got %0d strobes (at fall=%b) want 1 (at fall=1)", tag, stb, stb_first);
        end
    endtask

    // Reconfigure while running: sent in a low phase, applied at the next fall.
    task automatic reconfig(input logic [10:0] fc, input logic [3:0] res, input logic [1:0] mode,
                            input int old_hi, input logic [3:0] old_q, input logic [1:0] old_sel,
                            input string tag);
        int n = 0;
        int hi = 0;
        wait_fall(tag);
        send(fc, res, mode, tag);
        n_checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || q_obs !== old_q || sel_obs !== old_sel) begin
            n_fail++;
            $display("FAIL %s_pending: got busy=%b rdy=%b q=%b sel=%b want busy=1 rdy=0 q=%b sel=%b",
                     tag, busy, cfg_ready, q_obs, sel_obs, old_q, old_sel);
        end
        while (busy === 1'b1 && n < 400) begin
            if (sc_clk === 1'b1) hi++;
            @(negedge clk); n++;
        end
        n_checks++;
        if (hi != old_hi) begin
            n_fail++;
            $display("FAIL %s_last_high: got %0d cycles want %0d", tag, hi, old_hi);
        end
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || sc_clk !== 1'b0 || sample_stb !== 1'b1 ||
            q_obs !== res || sel_obs !== mode) begin
            n_fail++;
            $display("FAIL %s_applied: got busy=%b rdy=%b sc=%b stb=%b q=%b sel=%b want 0 1 0 1 %b %b",
                     tag, busy, cfg_ready, sc_clk, sample_stb, q_obs, sel_obs, res, mode);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_released");
    endtask

    task automatic test_start;
        send(11'd4, 4'b0101, 2'b00, "start");
        n_checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || q_obs !== 4'b0000 || sel_obs !== 2'b11) begin
            n_fail++;
            $display("FAIL start_accepted: got busy=%b rdy=%b q=%b sel=%b want 1 0 0000 11",
                     busy, cfg_ready, q_obs, sel_obs);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || q_obs !== 4'b0101 || sel_obs !== 2'b00 || sc_clk !== 1'b0) begin
            n_fail++;
            $display("FAIL start_applied: got busy=%b rdy=%b q=%b sel=%b sc=%b want 0 1 0101 00 0",
                     busy, cfg_ready, q_obs, sel_obs, sc_clk);
        end
        check_period("start", 4);
        check_period("start_again", 4);
    endtask

    task automatic test_reconfig;
        reconfig(11'd10, 4'b0010, 2'b10, 4, 4'b0101, 2'b00, "reconfig");
        check_period("reconfig", 10);
    endtask

    task automatic test_clamp;
        reconfig(11'd1, 4'b0111, 2'b01, 10, 4'b0010, 2'b10, "clamp");
        check_period("clamp", 2);
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int hi = 0;
        wait_fall("b2b");
        cfg_fc = 11'd3; cfg_res = 4'b1001; cfg_mode = 2'b01; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_fc = 11'd5; cfg_res = 4'b1100; cfg_mode = 2'b10;
        n_checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first_accept: got busy=%b rdy=%b want 1 0", busy, cfg_ready);
        end
        while (busy === 1'b1 && n < 400) begin
            if (sc_clk === 1'b1) hi++;
            @(negedge clk); n++;
        end
        n_checks++;
        if (hi != 2 || q_obs !== 4'b1001 || sel_obs !== 2'b01 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_applied: got hi=%0d q=%b sel=%b rdy=%b want 2 1001 01 1",
                     hi, q_obs, sel_obs, cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || q_obs !== 4'b1001 || sel_obs !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_second_accept: got busy=%b rdy=%b q=%b sel=%b want 1 0 1001 01",
                     busy, cfg_ready, q_obs, sel_obs);
        end
        n = 0; hi = 0;
        while (busy === 1'b1 && n < 400) begin
            if (sc_clk === 1'b1) hi++;
            @(negedge clk); n++;
        end
        n_checks++;
        if (hi != 3 || q_obs !== 4'b1100 || sel_obs !== 2'b10 || sample_stb !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_applied: got hi=%0d q=%b sel=%b stb=%b want 3 1100 10 1",
                     hi, q_obs, sel_obs, sample_stb);
        end
        check_period("b2b", 5);
    endtask

    task automatic test_stop;
        int hi = 0;
        int stb = 0;
        reconfig(11'd0, 4'b0011, 2'b11, 5, 4'b1100, 2'b10, "stop");
        repeat (40) begin
            @(negedge clk);
            if (sc_clk === 1'b1) hi++;
            if (sample_stb === 1'b1) stb++;
        end
        n_checks++;
        if (hi != 0 || stb != 0) begin
            n_fail++;
            $display("FAIL stop_quiet: got %0d high cycles, %0d strobes want 0 0", hi, stb);
        end
        n_checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || q_obs !== 4'b0011) begin
            n_fail++;
            $display("FAIL stop_idle: got rdy=%b busy=%b q=%b want 1 0 0011", cfg_ready, busy, q_obs);
        end
    endtask

    task automatic test_reset_mid_pend;
        int n = 0;
        int hi = 0;
        send(11'd4, 4'b0110, 2'b01, "rst_pend_start");
        @(negedge clk);
        wait_fall("rst_pend");
        send(11'd6, 4'b1010, 2'b10, "rst_pend");
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pend_pending: got busy=%b want 1", busy);
        end
        while (sc_clk !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (sc_clk !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pend_high: got sc=%b busy=%b want 1 1", sc_clk, busy);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_pend_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (sc_clk === 1'b1) hi++;
        end
        n_checks++;
        if (hi != 0) begin
            n_fail++;
            $display("FAIL rst_pend_discarded: got %0d high cycles want 0", hi);
        end
        check_reset_outputs("rst_pend_after");
    endtask

`ifdef SVF_CTRL_SOFT_Q_EN
    task automatic test_soft_q;
        int n = 0;
        int stb = 0;
        send(11'd4, 4'b0000, 2'b00, "soft_init");
        @(negedge clk);
        wait_fall("soft");
        send(11'd4, 4'b1111, 2'b00, "soft");
        while (q_obs !== 4'b1111 && n < 1000) begin
            @(negedge clk); n++;
            if (sample_stb === 1'b1) stb++;
        end
        // The apply-edge strobe plus fifteen stepping strobes.
        n_checks++;
        if (q_obs !== 4'b1111 || stb != 16) begin
            n_fail++;
            $display("FAIL soft_steps: got q=%b after %0d strobes want 1111 after 16", q_obs, stb);
        end
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL soft_release: got busy=%b rdy=%b want 0 1", busy, cfg_ready);
        end
    endtask
`endif

    initial begin
        test_reset;
`ifdef SVF_CTRL_SOFT_Q_EN
        test_soft_q;
`else
        test_start;
        test_reconfig;
        test_clamp;
        test_back_to_back;
        test_stop;
        test_reset_mid_pend;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
